// File: rtl/turn_pkg.sv
// Shared types and default parameters for the turn-switch input conditioner.
package turn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int COINC_CYCLES_DEF    = 8;
    localparam int TICK_DIV_DEF        = 8;

    typedef enum logic {
        DB_STABLE,
        DB_COUNT
    } db_state_e;

    typedef enum logic [1:0] {
        PAIR_IDLE,
        WAIT_L,
        WAIT_R
    } pair_state_e;

endpackage

// File: rtl/switch_debouncer.sv
// One switch channel: two-flop synchroniser followed by a consecutive-sample debouncer.
module switch_debouncer
    import turn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e        state_q, state_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        s1_d    = raw;
        s2_d    = s1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        unique case (state_q)
            DB_STABLE: begin
                if (s2_q != db_q) begin
                    state_d = DB_COUNT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            DB_COUNT: begin
                if (s2_q == db_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // This edge is the DEBOUNCE_CYCLES-th disagreeing sample.
                    db_d    = ~db_q;
                    cnt_d   = '0;
                    state_d = DB_STABLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= DB_STABLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/turn_input_conditioner.sv
// Turn-switch front end: per-side debounce, coincidence pairing of near-simultaneous presses,
// and a free-running step tick for the tail-light sequencer.
module turn_input_conditioner
    import turn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COINC_CYCLES    = COINC_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left,
    output logic right,
    output logic tick
);

    localparam int                 WAIT_W    = $clog2(COINC_CYCLES) + 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(COINC_CYCLES - 1);
    localparam int                 TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic db_left, db_right;

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk   (clk),
        .reset (reset),
        .raw   (left_raw),
        .db    (db_left)
    );

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk   (clk),
        .reset (reset),
        .raw   (right_raw),
        .db    (db_right)
    );

    pair_state_e       pair_state_q, pair_state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              left_q, left_d;
    logic              right_q, right_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_q, tick_d;
    logic              rise_l, rise_r;

    always_comb begin
        pair_state_d = pair_state_q;
        wait_d       = wait_q;
        left_d       = left_q;
        right_d      = right_q;
        rise_l       = db_left  && !left_q;
        rise_r       = db_right && !right_q;

        case (pair_state_q)
            PAIR_IDLE: begin
                wait_d = '0;
                if (rise_l && rise_r) begin
                    left_d  = 1'b1;
                    right_d = 1'b1;
                end else if (rise_l) begin
                    // Other side already lit means a hazard is in progress: no need to wait.
                    if (right_q) left_d = 1'b1;
                    else         pair_state_d = WAIT_L;
                end else if (rise_r) begin
                    if (left_q) right_d = 1'b1;
                    else        pair_state_d = WAIT_R;
                end
            end
            WAIT_L: begin
                if (!db_left) begin
                    pair_state_d = PAIR_IDLE;
                    wait_d       = '0;
                end else if (db_right) begin
                    left_d       = 1'b1;
                    right_d      = 1'b1;
                    pair_state_d = PAIR_IDLE;
                    wait_d       = '0;
                end else if (wait_q == WAIT_LAST) begin
                    left_d       = 1'b1;
                    pair_state_d = PAIR_IDLE;
                    wait_d       = '0;
                end else begin
                    wait_d       = wait_q + 1'b1;
                end
            end
            WAIT_R: begin
                if (!db_right) begin
                    pair_state_d = PAIR_IDLE;
                    wait_d       = '0;
                end else if (db_left) begin
                    left_d       = 1'b1;
                    right_d      = 1'b1;
                    pair_state_d = PAIR_IDLE;
                    wait_d       = '0;
                end else if (wait_q == WAIT_LAST) begin
                    right_d      = 1'b1;
                    pair_state_d = PAIR_IDLE;
                    wait_d       = '0;
                end else begin
                    wait_d       = wait_q + 1'b1;
                end
            end
            default: begin
                pair_state_d = PAIR_IDLE;
                wait_d       = '0;
            end
        endcase

        // Releases win over everything else and never wait.
        if (!db_left)  left_d  = 1'b0;
        if (!db_right) right_d = 1'b0;
    end

    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        tick_d     = (tick_cnt_d == TICK_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_state_q <= PAIR_IDLE;
            wait_q       <= '0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
        end else begin
            pair_state_q <= pair_state_d;
            wait_q       <= wait_d;
            left_q       <= left_d;
            right_q      <= right_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_q       <= tick_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Scoreboard bench for turn_input_conditioner: an edge-by-edge reference model fills a queue,
// a negedge monitor compares, and directed scenarios add explicit latency checks.
module tb_turn_input_conditioner;
    import turn_pkg::*;

    localparam int DB_N    = 4;
    localparam int CO_N    = 3;
    localparam int TD_N    = 4;
    localparam int CO_LONG = 8;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic left_raw  = 1'b0;
    logic right_raw = 1'b0;
    logic left, right, tick;
    logic left_long, right_long, tick_long;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    turn_input_conditioner #(
        .DEBOUNCE_CYCLES(DB_N), .COINC_CYCLES(CO_N), .TICK_DIV(TD_N)
    ) dut (
        .clk(clk), .reset(reset), .left_raw(left_raw), .right_raw(right_raw),
        .left(left), .right(right), .tick(tick)
    );

    // Longer coincidence window so a release can overtake a pending lone press.
    turn_input_conditioner #(
        .DEBOUNCE_CYCLES(DB_N), .COINC_CYCLES(CO_LONG), .TICK_DIV(TD_N)
    ) dut_long (
        .clk(clk), .reset(reset), .left_raw(left_raw), .right_raw(right_raw),
        .left(left_long), .right(right_long), .tick(tick_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = left, 1 = right. Outputs are judged against debounced levels from before each edge.
    bit m_s1[2], m_s2[2], m_db[2], m_out[2];
    int m_run[2];
    int m_pend[2];
    int m_edge = 0;
    int m_since_rst = 0;

    always @(posedge clk) begin : model
        bit         raw_now[2];
        bit         db_old[2];
        bit         rise[2];
        int         w;
        int         o;
        logic [2:0] e;
        raw_now[0] = left_raw;
        raw_now[1] = right_raw;
        m_edge++;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_out[c] = 0;
                m_run[c] = 0; m_pend[c] = -1;
            end
            m_since_rst = 0;
        end else begin
            m_since_rst++;
            db_old = m_db;
            w = (m_pend[0] >= 0) ? 0 : (m_pend[1] >= 0) ? 1 : -1;
            if (w >= 0) begin
                o = 1 - w;
                if (!db_old[w]) m_pend[w] = -1;
                else if (db_old[o]) begin
                    m_out[0] = 1; m_out[1] = 1; m_pend[w] = -1;
                end else if (m_edge - m_pend[w] == CO_N) begin
                    m_out[w] = 1; m_pend[w] = -1;
                end
            end else begin
                for (int c = 0; c < 2; c++) rise[c] = db_old[c] && !m_out[c];
                if (rise[0] && rise[1]) begin
                    m_out[0] = 1; m_out[1] = 1;
                end else begin
                    for (int c = 0; c < 2; c++)
                        if (rise[c]) begin
                            if (m_out[1-c]) m_out[c] = 1;
                            else            m_pend[c] = m_edge;
                        end
                end
            end
            for (int c = 0; c < 2; c++) if (!db_old[c]) m_out[c] = 0;
            // A level flips only after DB_N consecutive disagreeing synchronised samples.
            for (int c = 0; c < 2; c++) begin
                if (m_s2[c] != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB_N) begin
                        m_db[c]  = !m_db[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_now;
        end
        e = {m_out[0], m_out[1], (m_since_rst % TD_N) == TD_N - 1};
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty @%0t: no expected entry for DUT outputs", $time);
        end else begin
            e = exp_q.pop_front();
            check("outputs_left_right_tick", 32'({left, right, tick}), 32'(e));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin : stim
        bit seen;
        bit seen_long;
        int p;

        // Reset then idle: tick is high during the cycles that end at edges 4, 8, 12.
        step(); step();
        check("reset_left", 32'(left), 32'd0);
        check("reset_right", 32'(right), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_pair_idle", 32'(dut.pair_state_q), 32'(PAIR_IDLE));
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("idle_tick", 32'(tick), 32'((e % 4) == 3));
        end

        // Clean lone left press and release.
        left_raw = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 9)  check("lone_left_not_yet", 32'(left), 32'd0);
            if (e == 10) check("lone_left_on", 32'(left), 32'd1);
            if (e == 10) check("lone_left_right_off", 32'(right), 32'd0);
            if (e == 20) left_raw = 1'b0;
            if (e == 26) check("release_left_still_on", 32'(left), 32'd1);
            if (e == 27) check("release_left_off", 32'(left), 32'd0);
        end
        idle(6);

        // Bounce: two-cycle pulses never reach the debounced level.
        seen = 0;
        for (int e = 0; e < 16; e++) begin
            left_raw = (e < 8) ? ((e % 4) < 2) : 1'b0;
            step();
            seen |= left;
        end
        idle(4);
        check("bounce_left_never", 32'(seen), 32'd0);
        check("bounce_counter_zero", 32'(dut.u_db_left.cnt_q), 32'd0);

        // Hazard with skew: both outputs rise together, never left alone.
        seen = 0;
        left_raw = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 2) right_raw = 1'b1;
            seen |= (left && !right);
            if (e == 8) check("hazard_not_yet", 32'({left, right}), 32'b00);
            if (e == 9) check("hazard_both_on", 32'({left, right}), 32'b11);
        end
        check("hazard_no_lone_left", 32'(seen), 32'd0);
        left_raw = 1'b0; right_raw = 1'b0;
        idle(12);

        // Pass-through: right already lit, left follows with no coincidence wait.
        right_raw = 1'b1;
        idle(14);
        check("pass_right_on", 32'(right), 32'd1);
        left_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6) check("pass_left_not_yet", 32'(left), 32'd0);
            if (e == 7) check("pass_left_on", 32'(left), 32'd1);
        end
        left_raw = 1'b0; right_raw = 1'b0;
        idle(12);

        // Abort: a release reaches the pair stage before the long window expires.
        seen_long = 0;
        left_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 4) left_raw = 1'b0;
            if (e == 8) check("abort_waiting", 32'(dut_long.pair_state_q), 32'(WAIT_L));
            seen_long |= left_long;
        end
        check("abort_left_never", 32'(seen_long), 32'd0);
        check("abort_pair_idle", 32'(dut_long.pair_state_q), 32'(PAIR_IDLE));
        idle(4);

        // Reset in the middle of a wait, then full re-latency.
        left_raw = 1'b1;
        idle(7);
        check("midwait_in_wait_l", 32'(dut.pair_state_q), 32'(WAIT_L));
        reset = 1'b1;
        step();
        check("midwait_reset_outputs", 32'({left, right}), 32'b00);
        check("midwait_reset_idle", 32'(dut.pair_state_q), 32'(PAIR_IDLE));
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 9)  check("rerun_left_not_yet", 32'(left), 32'd0);
            if (e == 10) check("rerun_left_on", 32'(left), 32'd1);
        end
        left_raw = 1'b0;
        idle(10);

        // Randomised bouncing, skewed presses and occasional resets, checked by the scoreboard.
        for (int seg = 0; seg < 12; seg++) begin
            p = (seg % 3 == 0) ? 3 : (seg % 3 == 1) ? 12 : 40;
            for (int i = 0; i < 60; i++) begin
                step();
                reset = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, p - 1) == 0) left_raw  = ~left_raw;
                if ($urandom_range(0, p - 1) == 0) right_raw = ~right_raw;
                if (p == 40 && $urandom_range(0, 59) == 0) begin
                    left_raw  = ~left_raw;
                    right_raw = left_raw;
                end
            end
        end
        reset = 1'b0; left_raw = 1'b0; right_raw = 1'b0;
        idle(20);
        check("final_outputs_low", 32'({left, right}), 32'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
